// File: rtl/moore_seq_detector.sv
`default_nettype none
// ============================================================================
// Module  : moore_seq_detector
// Brief   : Moore serial pattern detector (KMP transition table built at
//           elaboration) with saturating match counter.
//           Build macro MOORE_SEQ_OVERLAP_EN selects overlapping detection.
// Revision: 1.0  initial release
// ============================================================================
module moore_seq_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic                         i_x,
  input  logic                         i_clr_cnt,
  output logic                         o_y,
  output logic [$clog2(PAT_W+1)-1:0]   o_state,
  output logic [CNT_W-1:0]             o_match_cnt,
  output logic                         o_cnt_sat
);

  localparam int SW    = $clog2(PAT_W + 1);
  localparam int NS    = PAT_W + 1;
  localparam int TBL_W = NS * 2 * SW;

`ifdef MOORE_SEQ_OVERLAP_EN
  localparam bit C_OVERLAP = 1'b1;
`else
  localparam bit C_OVERLAP = 1'b0;
`endif

  typedef enum logic [SW-1:0] {
    S_0 = '0
  } state_t;

  localparam state_t               S_PAT_W = state_t'(PAT_W);
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  // Entry (k*2+b) holds the successor of S_k on input bit b.
  function automatic logic [TBL_W-1:0] f_build_table();
    int               pb   [0:16];
    int               fl   [0:16];
    int               dt0  [0:16];
    int               dt1  [0:16];
    int               j;
    int               base;
    logic [PAT_W-1:0] sh;
    logic [TBL_W-1:0] tbl;
    tbl = '0;
    sh  = PATTERN;
    for (int k = 0; k <= 16; k++) begin
      pb[k]  = 0;
      fl[k]  = 0;
      dt0[k] = 0;
      dt1[k] = 0;
    end
    for (int k = 0; k < PAT_W; k++) begin
      pb[k] = sh[PAT_W-1] ? 1 : 0;
      sh    = sh << 1;
    end
    // Failure function: fl[k] = longest proper border of the k-bit prefix.
    for (int k = 2; k <= PAT_W; k++) begin
      j = fl[k-1];
      while (j > 0 && pb[j] != pb[k-1]) j = fl[j];
      if (pb[j] == pb[k-1]) j = j + 1;
      fl[k] = j;
    end
    for (int k = 0; k < PAT_W; k++) begin
      dt0[k] = (pb[k] == 0) ? k + 1 : ((k == 0) ? 0 : dt0[fl[k]]);
      dt1[k] = (pb[k] == 1) ? k + 1 : ((k == 0) ? 0 : dt1[fl[k]]);
    end
    base       = C_OVERLAP ? fl[PAT_W] : 0;
    dt0[PAT_W] = dt0[base];
    dt1[PAT_W] = dt1[base];
    for (int k = 0; k <= PAT_W; k++) begin
      tbl[(k*2)*SW   +: SW] = SW'(dt0[k]);
      tbl[(k*2+1)*SW +: SW] = SW'(dt1[k]);
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL = f_build_table();

  state_t            w_tbl [0:NS-1][0:1];
  state_t            r_state;
  state_t            w_state_next;
  state_t            w_lookup;
  logic              w_match;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  r_match_cnt;
  logic              r_cnt_sat;

  generate
    for (genvar k = 0; k < NS; k++) begin : g_tbl
      for (genvar b = 0; b < 2; b++) begin : g_bit
        assign w_tbl[k][b] = state_t'(NEXT_TBL[(k*2+b)*SW +: SW]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_0;
      r_match_cnt <= '0;
      r_cnt_sat   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_match_cnt <= w_cnt_next;
      r_cnt_sat   <= (w_cnt_next == CNT_MAX);
    end
  end

  always_comb begin
    w_lookup     = S_0;
    w_state_next = r_state;
    w_match      = 1'b0;
    w_cnt_next   = r_match_cnt;
    // Unreachable encodings above S_PAT_W recover to S_0.
    if (r_state <= S_PAT_W) begin
      w_lookup = w_tbl[r_state][i_x];
    end
    if (i_en) begin
      w_state_next = w_lookup;
      w_match      = (w_lookup == S_PAT_W);
    end
    if (i_clr_cnt) begin
      w_cnt_next = w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_match_cnt != CNT_MAX)) begin
      w_cnt_next = r_match_cnt + CNT_W'(1);
    end
  end

  assign o_y         = (r_state == S_PAT_W);
  assign o_state     = r_state;
  assign o_match_cnt = r_match_cnt;
  assign o_cnt_sat   = r_cnt_sat;

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_detector.sv
`default_nettype none
// Bench for moore_seq_detector: two instances (1011/CNT_W=8 and 111/CNT_W=2),
// behavioural history-window model feeding a scoreboard, plus directed constants.
module tb_moore_seq_detector;

`ifdef MOORE_SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, x_a = 1'b0, clr_a = 1'b0;
  logic en_b = 1'b0, x_b = 1'b0, clr_b = 1'b0;
  logic       y_a, sat_a, y_b, sat_b;
  logic [2:0] st_a;
  logic [7:0] cnt_a;
  logic [1:0] st_b;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .i_en(en_a), .i_x(x_a), .i_clr_cnt(clr_a),
    .o_y(y_a), .o_state(st_a), .o_match_cnt(cnt_a), .o_cnt_sat(sat_a)
  );

  moore_seq_detector #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .i_en(en_b), .i_x(x_b), .i_clr_cnt(clr_b),
    .o_y(y_b), .o_state(st_b), .o_match_cnt(cnt_b), .o_cnt_sat(sat_b)
  );

  typedef struct {
    int st;
    bit y;
    int cnt;
    bit sat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;

  int          pw   [2] = '{4, 3};
  logic [15:0] pat  [2] = '{16'h000B, 16'h0007};
  int          cmax [2] = '{255, 3};
  logic [15:0] hist [2];
  int          hlen [2];
  int          mst  [2];
  int          mcnt [2];

  // Longest k such that the k newest sampled bits equal the first k pattern bits.
  function automatic int longest(int u);
    for (int k = pw[u]; k > 0; k--) begin
      if (k <= hlen[u]) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (hist[u][i] != pat[u][pw[u]-k+i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_edge(input int u, input bit r, input bit e, input bit xx, input bit c);
    bit   match;
    exp_t ex;
    match = 1'b0;
    if (r) begin
      hist[u] = '0; hlen[u] = 0; mst[u] = 0; mcnt[u] = 0;
    end else begin
      if (e) begin
        hist[u] = {hist[u][14:0], xx};
        if (hlen[u] < 16) hlen[u]++;
        mst[u] = longest(u);
        match  = (mst[u] == pw[u]);
        if (match && !OVL) hlen[u] = 0;
      end
      if (c) mcnt[u] = match ? 1 : 0;
      else if (match && mcnt[u] < cmax[u]) mcnt[u]++;
    end
    ex.st  = mst[u];
    ex.y   = (mst[u] == pw[u]);
    ex.cnt = mcnt[u];
    ex.sat = (mcnt[u] == cmax[u]);
    sb.push_back(ex);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic do_edge(input bit r, input bit ea, input bit xa, input bit ca,
                         input bit eb, input bit xb, input bit cb);
    exp_t e0, e1;
    rst = r; en_a = ea; x_a = xa; clr_a = ca; en_b = eb; x_b = xb; clr_b = cb;
    model_edge(0, r, ea, xa, ca);
    model_edge(1, r, eb, xb, cb);
    @(posedge clk);
    #1;
    edge_n++;
    e0 = sb.pop_front();
    e1 = sb.pop_front();
    chk("A_state", 32'(st_a), 32'(e0.st));
    chk("A_y",     32'(y_a),  32'(e0.y));
    chk("A_cnt",   32'(cnt_a), 32'(e0.cnt));
    chk("A_sat",   32'(sat_a), 32'(e0.sat));
    chk("B_state", 32'(st_b), 32'(e1.st));
    chk("B_y",     32'(y_b),  32'(e1.y));
    chk("B_cnt",   32'(cnt_b), 32'(e1.cnt));
    chk("B_sat",   32'(sat_b), 32'(e1.sat));
  endtask

  task automatic a_bit(input bit xx);
    do_edge(0, 1, xx, 0, 0, 0, 0);
  endtask

  task automatic reset_all();
    do_edge(1, 1, 1, 1, 1, 1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seq;
    reset_all();
    reset_all();
    chk("rst_state_a", 32'(st_a), 0);
    chk("rst_y_a",     32'(y_a), 0);
    chk("rst_cnt_a",   32'(cnt_a), 0);
    chk("rst_sat_b",   32'(sat_b), 0);

    // 1,0,1,1,0,1,1
    a_bit(1); a_bit(0); a_bit(1); a_bit(1);
    chk("tp1_y_e4", 32'(y_a), 1);
    a_bit(0); a_bit(1); a_bit(1);
    chk("tp1_state_e7", 32'(st_a), OVL ? 4 : 1);
    chk("tp1_y_e7",     32'(y_a),  OVL ? 1 : 0);
    chk("tp1_cnt_e7",   32'(cnt_a), OVL ? 2 : 1);

    // en gating: x ignored while en=0
    reset_all();
    a_bit(1); a_bit(0);
    for (int i = 0; i < 3; i++) do_edge(0, 0, i[0], 0, 0, 0, 0);
    chk("tp3_hold_state", 32'(st_a), 2);
    a_bit(1); a_bit(1);
    chk("tp3_state", 32'(st_a), 4);
    chk("tp3_y",     32'(y_a), 1);
    do_edge(0, 0, 0, 0, 0, 0, 0);
    chk("tp3_y_held", 32'(y_a), 1);
    chk("tp3_cnt",    32'(cnt_a), 1);

    // mid-sequence reset discards history
    reset_all();
    a_bit(1); a_bit(0); a_bit(1);
    reset_all();
    chk("tp5_state_rst", 32'(st_a), 0);
    a_bit(1);
    chk("tp5_state", 32'(st_a), 1);
    chk("tp5_cnt",   32'(cnt_a), 0);

    // clr_cnt coinciding with a match
    reset_all();
    seq = 4'b1011;
    for (int m = 0; m < 5; m++)
      for (int i = 3; i >= 0; i--) a_bit(seq[i]);
    chk("clr_pre_cnt", 32'(cnt_a), 5);
    a_bit(1); a_bit(0); a_bit(1);
    do_edge(0, 1, 1, 1, 0, 0, 0);
    chk("clr_match_cnt", 32'(cnt_a), 1);
    chk("clr_match_y",   32'(y_a), 1);
    chk("clr_match_sat", 32'(sat_a), 0);
    do_edge(0, 0, 0, 1, 0, 0, 0);
    chk("clr_only_cnt", 32'(cnt_a), 0);
    chk("clr_only_y",   32'(y_a), 1);

    // saturation on the 2-bit counter, pattern 111
    reset_all();
    for (int i = 0; i < 6; i++) begin
      do_edge(0, 0, 0, 0, 1, 1, 0);
      if (i == 4) chk("sat_e5", 32'(sat_b), OVL ? 1 : 0);
    end
    chk("sat_cnt_e6", 32'(cnt_b), OVL ? 3 : 2);
    chk("sat_y_e6",   32'(y_b), 1);
    for (int i = 0; i < 3; i++) do_edge(0, 0, 0, 0, 1, 1, 0);
    chk("sat_cnt_e9", 32'(cnt_b), 3);
    chk("sat_flag_e9", 32'(sat_b), 1);
    do_edge(0, 0, 0, 0, 0, 1, 1);
    chk("sat_clr_cnt", 32'(cnt_b), 0);
    chk("sat_clr_sat", 32'(sat_b), 0);
    chk("sat_clr_y",   32'(y_b), 1);

    // random traffic on both instances
    reset_all();
    for (int i = 0; i < 60; i++)
      do_edge(0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
